// File: rtl/desired_drive_seq_pkg.sv
// Shared types, widths and helpers for the assist-current sequencer.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
package desired_drive_pkg;

  localparam logic [11:0] TORQUE_MIN_DEF = 12'h380;

  localparam int W_TORQUE = 12;  // avg_torque, torque_pos, target_curr
  localparam int W_TOFF   = 13;  // torque minus offset, sign bit on top
  localparam int W_LIM    = 9;   // incline_lim and multiplier B operand
  localparam int W_CF     = 6;   // cadence_factor
  localparam int W_CS     = 8;   // cadence_factor * setting
  localparam int W_A      = 21;  // multiplier A operand and p1
  localparam int W_PROD   = 29;  // final product kept for saturation
  localparam int W_RES    = W_A + W_LIM;

  // Product bits that force full scale, and the slice that becomes the output
  localparam int SAT_HI = 28;
  localparam int SAT_LO = 26;
  localparam int OUT_HI = 25;
  localparam int OUT_LO = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_A = 2'd1,
    MUL_B = 2'd2,
    SAT   = 2'd3
  } state_t;

  // Clip incline to 10b signed, bias by +256, clamp to the 9b unsigned range
  function automatic logic [W_LIM-1:0] incline_limit(input logic signed [12:0] inc);
    logic signed [9:0]  inc_sat;
    logic signed [10:0] factor;
    if (inc > 13'sd511)
      inc_sat = 10'sd511;
    else if (inc < -13'sd512)
      inc_sat = -10'sd512;
    else
      inc_sat = inc[9:0];
    factor = {inc_sat[9], inc_sat} + 11'sd256;
    if (factor[10])
      return '0;
    else if (factor > 11'sd511)
      return 9'd511;
    else
      return factor[8:0];
  endfunction

endpackage

// File: rtl/desired_drive_seq_drv_mult.sv
// Shared unsigned 21x9 multiplier with MUL_LAT register stages, no reset on data.
// Latency: MUL_LAT cycles from operands to p.
// Backpressure: none; loads every cycle, the sequencer decides when p is meaningful.
module drv_mult
  import desired_drive_pkg::*;
#(
  parameter int MUL_LAT = 1
) (
  input  logic             clk,
  input  logic [W_A-1:0]   a,
  input  logic [W_LIM-1:0] b,
  output logic [W_RES-1:0] p
);

  logic [W_RES-1:0] pipe_q [MUL_LAT];

  // Multiply into the first stage, then shift down the pipeline
  always_ff @(posedge clk) begin
    pipe_q[0] <= {{W_LIM{1'b0}}, a} * {{W_A{1'b0}}, b};
    for (int i = 1; i < MUL_LAT; i++)
      pipe_q[i] <= pipe_q[i-1];
  end

  assign p = pipe_q[MUL_LAT-1];

endmodule

// File: rtl/desired_drive_seq.sv
// Assist-current sequencer: two passes through one shared multiplier, then saturate.
// Latency: calc_done 2*MUL_LAT+3 cycles after the start edge (2 with ZERO_SHORTCUT_EN on a zero factor).
// Backpressure: strt_calc is ignored while busy; nothing is queued. Option macro: ZERO_SHORTCUT_EN.
module desired_drive_seq
  import desired_drive_pkg::*;
#(
  parameter logic [11:0] TORQUE_MIN = TORQUE_MIN_DEF,
  parameter int          MUL_LAT    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                strt_calc,
  input  logic [W_TORQUE-1:0] avg_torque,
  input  logic [4:0]          cadence_vec,
  input  logic [12:0]         incline,
  input  logic [1:0]          setting,
  output logic [W_TORQUE-1:0] target_curr,
  output logic                busy,
  output logic                calc_done
);

  // MUL_A spends one extra cycle so p1 can be fed straight back into the multiplier
  localparam logic [1:0] LAST_A = 2'(MUL_LAT);
  localparam logic [1:0] LAST_B = 2'(MUL_LAT - 1);

  state_t                state_q;
  logic [1:0]            cnt_q;
  logic [W_TORQUE-1:0]   torque_pos_q;
  logic [W_LIM-1:0]      incline_lim_q;
  logic [W_CS-1:0]       cs_q;
  logic [W_A-1:0]        p1_q;
  logic [W_PROD-1:0]     prod_q;

  logic [W_TOFF-1:0]     torque_off;
  logic [W_TORQUE-1:0]   torque_pos;
  logic [W_LIM-1:0]      incline_lim;
  logic [W_CF-1:0]       cadence_factor;
  logic [W_CS-1:0]       cs;
  logic [W_A-1:0]        mul_a;
  logic [W_LIM-1:0]      mul_b;
  logic [W_RES-1:0]      mul_p;
  logic                  mul_p_unused;

  // Factors from the live inputs; only the start edge registers them
  always_comb begin
    torque_off     = {1'b0, avg_torque} - {1'b0, TORQUE_MIN};
    torque_pos     = torque_off[W_TOFF-1] ? '0 : torque_off[W_TORQUE-1:0];
    incline_lim    = incline_limit(incline);
    cadence_factor = (cadence_vec > 5'd1) ? ({1'b0, cadence_vec} + 6'd32) : '0;
    cs             = ({2'b00, cadence_factor} & {W_CS{setting[0]}})
                   + ({1'b0, cadence_factor, 1'b0} & {W_CS{setting[1]}});
  end

  // Operand select; last MUL_A cycle presents the fresh p1 so pass two starts immediately
  always_comb begin
    mul_a = {{(W_A-W_TORQUE){1'b0}}, torque_pos_q};
    mul_b = incline_lim_q;
    if (state_q == MUL_A && cnt_q == LAST_A) begin
      mul_a = mul_p[W_A-1:0];
      mul_b = {1'b0, cs_q};
    end else if (state_q == MUL_B) begin
      mul_a = p1_q;
      mul_b = {1'b0, cs_q};
    end
  end

  drv_mult #(.MUL_LAT(MUL_LAT)) u_mult (
    .clk (clk),
    .a   (mul_a),
    .b   (mul_b),
    .p   (mul_p)
  );

  // Top product bit is always zero for in-range operands
  assign mul_p_unused = mul_p[W_RES-1];

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      torque_pos_q  <= '0;
      incline_lim_q <= '0;
      cs_q          <= '0;
      p1_q          <= '0;
      prod_q        <= '0;
      target_curr   <= '0;
      busy          <= 1'b0;
      calc_done     <= 1'b0;
    end else begin
      calc_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (strt_calc) begin
            torque_pos_q  <= torque_pos;
            incline_lim_q <= incline_lim;
            cs_q          <= cs;
            cnt_q         <= '0;
            busy          <= 1'b1;
`ifdef ZERO_SHORTCUT_EN
            if (torque_pos == '0 || incline_lim == '0 || cs == '0) begin
              prod_q  <= '0;
              state_q <= SAT;
            end else begin
              state_q <= MUL_A;
            end
`else
            state_q <= MUL_A;
`endif
          end
        end
        MUL_A: begin
          if (cnt_q == LAST_A) begin
            p1_q    <= mul_p[W_A-1:0];
            cnt_q   <= '0;
            state_q <= MUL_B;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        MUL_B: begin
          if (cnt_q == LAST_B) begin
            prod_q  <= mul_p[W_PROD-1:0];
            state_q <= SAT;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        SAT: begin
          target_curr <= (|prod_q[SAT_HI:SAT_LO]) ? 12'hFFF : prod_q[OUT_HI:OUT_LO];
          calc_done   <= 1'b1;
          busy        <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_desired_drive_seq.sv
// Bench for desired_drive_seq: directed vectors plus randomized calcs against an arithmetic model.
// Latency: checks calc_done timing for MUL_LAT=1 and a MUL_LAT=3 instance.
// Backpressure: checks that starts while busy are dropped and done-cycle restarts are taken.
module tb_desired_drive_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strt_calc = 1'b0;
  logic        strt3 = 1'b0;
  logic [11:0] avg_torque = '0;
  logic [4:0]  cadence_vec = '0;
  logic [12:0] incline = '0;
  logic [1:0]  setting = '0;
  logic [11:0] target_curr, tc3;
  logic        busy, busy3, calc_done, done3;

  int checks = 0;
  int failures = 0;

`ifdef ZERO_SHORTCUT_EN
  localparam bit SHORT = 1'b1;
`else
  localparam bit SHORT = 1'b0;
`endif

  always #5 clk = ~clk;

  desired_drive_seq u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .strt_calc   (strt_calc),
    .avg_torque  (avg_torque),
    .cadence_vec (cadence_vec),
    .incline     (incline),
    .setting     (setting),
    .target_curr (target_curr),
    .busy        (busy),
    .calc_done   (calc_done)
  );

  desired_drive_seq #(.MUL_LAT(3)) u_dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .strt_calc   (strt3),
    .avg_torque  (avg_torque),
    .cadence_vec (cadence_vec),
    .incline     (incline),
    .setting     (setting),
    .target_curr (tc3),
    .busy        (busy3),
    .calc_done   (done3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference factors straight from the arithmetic rules
  function automatic void ref_factors(input logic [11:0] t, input logic [4:0] c,
                                      input logic signed [12:0] inc, input logic [1:0] s,
                                      output int tp, output int fac, output int csv);
    int iv, cf, sv, cv;
    tp = int'(t) - 'h380;
    if (tp < 0) tp = 0;
    iv = inc;
    if (iv > 511) iv = 511;
    if (iv < -512) iv = -512;
    fac = iv + 256;
    if (fac < 0) fac = 0;
    if (fac > 511) fac = 511;
    cv = c;
    sv = s;
    cf = (cv > 1) ? cv + 32 : 0;
    csv = cf * sv;
  endfunction

  function automatic int ref_curr(input logic [11:0] t, input logic [4:0] c,
                                  input logic [12:0] inc, input logic [1:0] s);
    int tp, fac, csv;
    longint p;
    ref_factors(t, c, inc, s, tp, fac, csv);
    p = longint'(tp) * longint'(fac) * longint'(csv);
    if (p >= (longint'(1) << 26)) return 'hFFF;
    return int'(p >> 14);
  endfunction

  function automatic int ref_lat(input logic [11:0] t, input logic [4:0] c,
                                 input logic [12:0] inc, input logic [1:0] s, input int lat);
    int tp, fac, csv;
    ref_factors(t, c, inc, s, tp, fac, csv);
    if (SHORT && (tp == 0 || fac == 0 || csv == 0)) return 2;
    return 2 * lat + 3;
  endfunction

  // Present a vector with strt_calc across one rising edge; returns at the next falling edge
  task automatic launch(input logic [11:0] t, input logic [4:0] c,
                        input logic [12:0] inc, input logic [1:0] s);
    avg_torque  = t;
    cadence_vec = c;
    incline     = inc;
    setting     = s;
    strt_calc   = 1'b1;
    @(negedge clk);
    strt_calc = 1'b0;
  endtask

  // Called at the falling edge of cycle first_cycle after the start edge; returns in the done cycle
  task automatic wait_done(input string tag, input int exp_val, input int exp_lat, input int first_cycle);
    int lat;
    int bcnt;
    bit moved;
    logic [11:0] held;
    lat = first_cycle;
    bcnt = 0;
    moved = 1'b0;
    held = target_curr;
    while (!calc_done && lat < 60) begin
      if (busy) bcnt++;
      if (target_curr !== held) moved = 1'b1;
      @(negedge clk);
      lat++;
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".busy_cycles"}, bcnt, exp_lat - first_cycle);
    check({tag, ".held"}, moved, 0);
    check({tag, ".val"}, target_curr, exp_val);
    check({tag, ".busy_in_done"}, busy, 0);
  endtask

  task automatic pulse_end(input string tag);
    @(negedge clk);
    check({tag, ".done_width"}, calc_done, 0);
  endtask

  task automatic run_one(input string tag, input logic [11:0] t, input logic [4:0] c,
                         input logic [12:0] inc, input logic [1:0] s);
    @(negedge clk);
    launch(t, c, inc, s);
    wait_done(tag, ref_curr(t, c, inc, s), ref_lat(t, c, inc, s, 1), 1);
    pulse_end(tag);
  endtask

  initial begin
    int extra;
    int lat3;
    logic [11:0] rt;
    logic [4:0]  rc;
    logic [12:0] ri;
    logic [1:0]  rs;

    // Reset state
    @(negedge clk);
    check("rst.target", target_curr, 0);
    check("rst.busy", busy, 0);
    check("rst.done", calc_done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    run_one("v1", 12'h800, 5'd10, 13'h0000, 2'd2);
    check("v1.const", target_curr, 12'h5E8);
    run_one("v2", 12'hFFF, 5'd31, 13'h0FFF, 2'd3);
    check("v2.const", target_curr, 12'hFFF);
    run_one("lowtorque", 12'h300, 5'd10, 13'h0000, 2'd2);
    check("lowtorque.const", target_curr, 0);
    run_one("neginc", 12'h800, 5'd10, 13'h1E00, 2'd2);
    run_one("lowcad", 12'h800, 5'd1, 13'h0000, 2'd2);
    run_one("set0", 12'h800, 5'd10, 13'h0000, 2'd0);

    // Start during MUL_A is dropped; restart in the done cycle is taken
    run_one("pre", 12'h900, 5'd20, 13'h0040, 2'd1);
    @(negedge clk);
    launch(12'h800, 5'd10, 13'h0000, 2'd2);
    avg_torque  = 12'hFFF;
    cadence_vec = 5'd31;
    incline     = 13'h0FFF;
    setting     = 2'd3;
    strt_calc   = 1'b1;
    @(negedge clk);
    strt_calc = 1'b0;
    wait_done("mid", 12'h5E8, 5, 2);
    launch(12'hFFF, 5'd31, 13'h0FFF, 2'd3);
    wait_done("restart", 12'hFFF, 5, 1);
    pulse_end("restart");

    // Reset during MUL_B aborts the calculation
    @(negedge clk);
    launch(12'h800, 5'd10, 13'h0000, 2'd2);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.target", target_curr, 0);
    check("abort.busy", busy, 0);
    check("abort.done", calc_done, 0);
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (calc_done) extra++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (calc_done) extra++;
    end
    check("abort.no_done", extra, 0);
    run_one("after_rst", 12'h800, 5'd10, 13'h0000, 2'd2);

    // Randomized vectors, every fourth one pushed toward range edges
    for (int n = 0; n < 40; n++) begin
      rt = 12'($urandom_range(0, 4095));
      rc = 5'($urandom);
      ri = 13'($urandom);
      rs = 2'($urandom);
      if (n % 4 == 0) begin
        rt = ($urandom_range(0, 1) == 1) ? 12'hFFF : 12'h381;
        ri = ($urandom_range(0, 1) == 1) ? 13'h00FF : 13'h1F00;
        rc = 5'd2;
      end
      run_one($sformatf("rnd%0d", n), rt, rc, ri, rs);
    end

    // Three-stage multiplier instance
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      avg_torque  = (v == 0) ? 12'h800 : 12'hFFF;
      cadence_vec = (v == 0) ? 5'd10 : 5'd31;
      incline     = (v == 0) ? 13'h0000 : 13'h0FFF;
      setting     = (v == 0) ? 2'd2 : 2'd3;
      strt3 = 1'b1;
      @(negedge clk);
      strt3 = 1'b0;
      lat3 = 1;
      while (!done3 && lat3 < 60) begin
        @(negedge clk);
        lat3++;
      end
      check($sformatf("lat3_%0d.lat", v), lat3, 9);
      check($sformatf("lat3_%0d.val", v), tc3, (v == 0) ? 12'h5E8 : 12'hFFF);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
